// File: rtl/imem_fetch.sv
// rtl/imem_fetch.sv - instruction fetch unit with 2-entry fetch buffer and redirect handling
module imem_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h4000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_en,
  output logic [12:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  input  logic        out_ready,
  output logic        fetch_fault
);

  localparam logic [1:0] FULL = FIFO_DEPTH[1:0];

  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic        fault_q, fault_d;
  // Slot 0 is always the head; slot 1 only holds data when two entries are buffered.
  logic [31:0] pc0_q, pc0_d, inst0_q, inst0_d;
  logic [31:0] pc1_q, pc1_d, inst1_q, inst1_d;

  logic        pop;
  logic        fetch;
  logic [1:0]  wr_idx;

  // A redirect cancels both the consumer handshake and the memory read of this cycle.
  assign pop    = (count_q != 2'd0) && out_ready && !redirect_valid;
  assign fetch  = !rst && !fault_q && !redirect_valid && ((count_q < FULL) || pop);
  // Slot the new word lands in, after accounting for the head leaving this cycle.
  assign wr_idx = count_q - {1'b0, pop};

  assign imem_en     = fetch;
  assign imem_addr   = pc_q[12:0];
  assign out_valid   = (count_q != 2'd0);
  assign out_pc      = pc0_q;
  assign out_inst    = inst0_q;
  assign fetch_fault = fault_q;

  // Next-state: redirect flushes and reloads pc; otherwise shift on pop and append on fetch.
  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    fault_d = fault_q;
    pc0_d   = pc0_q;
    inst0_d = inst0_q;
    pc1_d   = pc1_q;
    inst1_d = inst1_q;
    if (redirect_valid) begin
      count_d = 2'd0;
      pc_d    = redirect_pc;
      fault_d = (redirect_pc[1:0] != 2'b00);
    end else begin
      // Only shift when a second entry exists, so the head holds its value once drained.
      if (pop && (count_q == 2'd2)) begin
        pc0_d   = pc1_q;
        inst0_d = inst1_q;
      end
      if (fetch) begin
        pc_d = pc_q + 32'd4;
        if (wr_idx == 2'd0) begin
          pc0_d   = pc_q;
          inst0_d = imem_rdata;
        end else begin
          pc1_d   = pc_q;
          inst1_d = imem_rdata;
        end
      end
      count_d = count_q + {1'b0, fetch} - {1'b0, pop};
    end
  end

  // State register; reset wins over redirect and handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      count_q <= 2'd0;
      fault_q <= 1'b0;
      pc0_q   <= 32'd0;
      inst0_q <= 32'd0;
      pc1_q   <= 32'd0;
      inst1_q <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      fault_q <= fault_d;
      pc0_q   <= pc0_d;
      inst0_q <= inst0_d;
      pc1_q   <= pc1_d;
      inst1_q <= inst1_d;
    end
  end

endmodule

// File: tb/tb_imem_fetch.sv
// tb/tb_imem_fetch.sv - self-checking bench for imem_fetch
module tb_imem_fetch;

  localparam logic [31:0] RST_PC = 32'h4000_0000;
  localparam logic [31:0] A = RST_PC;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_en;
  logic [12:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready;
  logic        fetch_fault;

  imem_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_ready      (out_ready),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  // Memory returns its own byte address as the instruction word.
  assign imem_rdata = {19'd0, imem_addr};

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_valid;
    logic        e_en;
    logic [12:0] e_addr;
    logic [31:0] e_pc;
    logic        e_fault;
  } vec_t;

  vec_t        tbl[29];
  logic [31:0] sbq[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_hs     = 0;
  int          hs_mark;
  logic        mon_en   = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_pc, prev_inst;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic vec_t v(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy,
                             input logic ev, input logic een, input logic [12:0] ea,
                             input logic [31:0] ep, input logic ef);
    vec_t t;
    t.rst = r; t.rv = rv; t.rpc = rpc; t.rdy = rdy;
    t.e_valid = ev; t.e_en = een; t.e_addr = ea; t.e_pc = ep; t.e_fault = ef;
    return t;
  endfunction

  // Expected accepted stream restarts at every reset/redirect target (none if misaligned).
  task automatic sb_restart(input logic [31:0] start, input int n);
    sbq.delete();
    if (start[1:0] == 2'b00)
      for (int k = 0; k < n; k++) sbq.push_back(start + 32'(4 * k));
  endtask

  // Scoreboard monitor: every accepted instruction is popped and compared; stalls must hold data.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst && !redirect_valid && out_valid && out_ready) begin
        n_hs++;
        chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
          logic [31:0] e;
          e = sbq.pop_front();
          chk("hs_pc", out_pc, e);
          chk("hs_inst", out_inst, {19'd0, e[12:0]});
        end
      end
      if (prev_stall && out_valid) begin
        chk("stall_pc_stable", out_pc, prev_pc);
        chk("stall_inst_stable", out_inst, prev_inst);
      end
      prev_stall = out_valid && !out_ready && !rst && !redirect_valid;
      prev_pc    = out_pc;
      prev_inst  = out_inst;
    end
  end

  initial begin
    // rst rv rpc rdy | valid en addr out_pc fault
    tbl[0]  = v(1, 0, 0, 1,            0, 0, 13'h0000, 32'h0, 0);
    tbl[1]  = v(0, 0, 0, 1,            0, 1, 13'h0000, 32'h0, 0);
    tbl[2]  = v(0, 0, 0, 1,            1, 1, 13'h0004, A, 0);
    tbl[3]  = v(0, 0, 0, 1,            1, 1, 13'h0008, A + 4, 0);
    tbl[4]  = v(0, 0, 0, 0,            1, 1, 13'h000C, A + 8, 0);
    tbl[5]  = v(0, 0, 0, 0,            1, 0, 13'h0010, A + 8, 0);
    tbl[6]  = v(1, 1, A + 32'h100, 1,  1, 0, 13'h0010, A + 8, 0);
    tbl[7]  = v(0, 0, 0, 0,            0, 1, 13'h0000, 32'h0, 0);
    tbl[8]  = v(0, 0, 0, 0,            1, 1, 13'h0004, A, 0);
    tbl[9]  = v(0, 0, 0, 0,            1, 0, 13'h0008, A, 0);
    tbl[10] = v(0, 0, 0, 0,            1, 0, 13'h0008, A, 0);
    tbl[11] = v(0, 0, 0, 0,            1, 0, 13'h0008, A, 0);
    tbl[12] = v(0, 0, 0, 1,            1, 1, 13'h0008, A, 0);
    tbl[13] = v(0, 0, 0, 0,            1, 0, 13'h000C, A + 4, 0);
    tbl[14] = v(0, 1, A + 32'h100, 1,  1, 0, 13'h000C, A + 4, 0);
    tbl[15] = v(0, 0, 0, 1,            0, 1, 13'h0100, A + 4, 0);
    tbl[16] = v(0, 0, 0, 1,            1, 1, 13'h0104, A + 32'h100, 0);
    tbl[17] = v(0, 1, A + 32'h102, 1,  1, 0, 13'h0108, A + 32'h104, 0);
    tbl[18] = v(0, 0, 0, 1,            0, 0, 13'h0102, A + 32'h104, 1);
    tbl[19] = v(0, 0, 0, 1,            0, 0, 13'h0102, A + 32'h104, 1);
    tbl[20] = v(0, 1, A, 1,            0, 0, 13'h0102, A + 32'h104, 1);
    tbl[21] = v(0, 0, 0, 1,            0, 1, 13'h0000, A + 32'h104, 0);
    tbl[22] = v(0, 0, 0, 1,            1, 1, 13'h0004, A, 0);
    tbl[23] = v(0, 1, 32'hFFFF_FFFC, 1, 1, 0, 13'h0008, A + 4, 0);
    tbl[24] = v(0, 0, 0, 1,            0, 1, 13'h1FFC, A + 4, 0);
    tbl[25] = v(0, 0, 0, 1,            1, 1, 13'h0000, 32'hFFFF_FFFC, 0);
    tbl[26] = v(0, 0, 0, 1,            1, 1, 13'h0004, 32'h0, 0);
    tbl[27] = v(1, 0, 0, 1,            1, 0, 13'h0008, 32'h4, 0);
    tbl[28] = v(0, 0, 0, 0,            0, 1, 13'h0000, 32'h0, 0);

    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    mon_en = 1'b1;

    for (int i = 0; i < 29; i++) begin
      @(posedge clk); #1;
      rst            = tbl[i].rst;
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      out_ready      = tbl[i].rdy;
      if (tbl[i].rst) sb_restart(RST_PC, 4);
      else if (tbl[i].rv) sb_restart(tbl[i].rpc, 4);
      @(negedge clk);
      chk($sformatf("row%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
      chk($sformatf("row%0d_imem_en", i), 32'(imem_en), 32'(tbl[i].e_en));
      chk($sformatf("row%0d_imem_addr", i), 32'(imem_addr), 32'(tbl[i].e_addr));
      chk($sformatf("row%0d_out_pc", i), out_pc, tbl[i].e_pc);
      chk($sformatf("row%0d_out_inst", i), out_inst, {19'd0, tbl[i].e_pc[12:0]});
      chk($sformatf("row%0d_fetch_fault", i), 32'(fetch_fault), 32'(tbl[i].e_fault));
    end
    chk("table_handshakes", 32'(n_hs), 32'd7);

    // Random backpressure stream: order, no loss, no duplication, stable while stalled.
    @(posedge clk); #1;
    rst = 1'b1; redirect_valid = 1'b0; out_ready = 1'b1;
    sb_restart(RST_PC, 400);
    hs_mark = n_hs;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 300; c++) begin
      out_ready = ($urandom_range(0, 1) == 1);
      @(posedge clk); #1;
    end
    chk("random_throughput_ok", 32'((n_hs - hs_mark) >= 50), 32'd1);
    chk("random_fifo_bounded", 32'((n_hs - hs_mark) <= 300), 32'd1);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_fetch.md
IMEM_FETCH -- requirements
Module: imem_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h4000_0000, SHALL be the first PC fetched after reset.
REQ-002 Parameter FIFO_DEPTH, default 2, SHALL set the fetch-buffer depth; only value 2 is required.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 redirect_valid  in  1  SHALL request a PC redirect (branch/jump/trap).
REQ-006 redirect_pc  in  32  SHALL be the redirect target byte address.
REQ-007 imem_en  out  1  SHALL be the instruction-memory read enable (BIOS port A).
REQ-008 imem_addr  out  13  SHALL be the byte address to the memory, equal to pc[12:0].
REQ-009 imem_rdata  in  32  SHALL be the read word; it is combinational, valid in the same cycle as imem_addr.
REQ-010 out_valid  out  1  SHALL flag a valid instruction to decode.
REQ-011 out_pc  out  32  SHALL be the PC of out_inst.
REQ-012 out_inst  out  32  SHALL be the instruction word.
REQ-013 out_ready  in  1  SHALL be the decode-stage accept.
REQ-014 fetch_fault  out  1  SHALL flag a misaligned redirect target (sticky).

Function
REQ-015 Internal state SHALL be: pc (32b), 2-entry FIFO of {pc, inst}, count (0..2), fault flag.
REQ-016 Pop SHALL occur when out_valid && out_ready and no redirect is active.
REQ-017 Fetch SHALL occur when not fault, not redirect, and (count<2 or pop); imem_en equals fetch.
REQ-018 On fetch the FIFO SHALL push {pc, imem_rdata} and pc SHALL become pc+4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
REQ-019 Simultaneous push and pop at count==2 or count==1 SHALL leave count unchanged and preserve order.
REQ-020 out_valid SHALL equal (count!=0); out_pc/out_inst SHALL come from the FIFO head, registered, with no combinational path from imem_rdata.
REQ-021 Latency: an instruction fetched in cycle N SHALL appear on the outputs in cycle N+1 when the FIFO is empty; throughput SHALL be 1 instruction/cycle with out_ready held high.
REQ-022 With out_ready low, the FIFO SHALL fill to 2, then imem_en SHALL drop and pc SHALL hold; out_pc/out_inst SHALL stay stable while out_valid && !out_ready.
REQ-023 redirect_valid SHALL flush the FIFO (count to 0) next edge, discard any same-cycle pop and fetch, and load pc with redirect_pc.
REQ-024 Redirect with redirect_pc[1:0]!=0 SHALL set the fault flag and still load pc; while the fault is set, fetch SHALL be suppressed.
REQ-025 An aligned redirect SHALL clear the fault flag.
REQ-026 The cycle after a redirect, fetch SHALL resume at the new pc, so out_valid is first high 2 cycles after redirect_valid.
REQ-027 When out_valid is low, out_pc/out_inst SHALL hold their last values; they carry no meaning.

Reset
REQ-028 When rst is high at a clock edge, the block SHALL set pc=RESET_PC, count=0, fault=0, out_valid=0, out_pc=0, out_inst=0, fetch_fault=0.
REQ-029 rst SHALL take priority over redirect_valid and out_ready in the same cycle.
REQ-030 Reset mid-stream SHALL discard FIFO contents; no stale instruction SHALL appear after reset.
REQ-031 imem_en SHALL be 0 while rst is high.
REQ-032 Fetch SHALL start in the first cycle after rst deasserts.

Verification
REQ-033 Streaming: release rst, out_ready=1, memory word = byte address -> out_valid rises the cycle after release; out_pc sequence 4000_0000, 4000_0004, 4000_0008, with out_inst matching.
REQ-034 Backpressure: out_ready=0 for 5 cycles -> count reaches 2, imem_en=0, out_pc holds 4000_0000; with out_ready=1, order continues 4000_0004 with no loss or duplication.
REQ-035 Redirect: redirect_valid with redirect_pc=4000_0100 while FIFO full and out_ready=1 -> next cycle out_valid=0, imem_addr=0x100; the cycle after, out_pc=4000_0100.
REQ-036 Misaligned redirect: redirect_pc=4000_0102 -> fetch_fault=1, imem_en=0 indefinitely; an aligned redirect to 4000_0000 clears the fault and fetch resumes.
REQ-037 Wrap: redirect to FFFF_FFFC -> out_pc FFFF_FFFC then 0000_0000.
REQ-038 Reset mid-op: assert rst with count=2 and redirect_valid=1 -> next cycle out_valid=0, imem_addr=RESET_PC[12:0], fetch_fault=0.
